pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//   Program-counter stage directly upstream of the instruction ROM. Holds the
//   byte address of the current instruction and drives it to the ROM's PC input.
//   Each retired cycle it selects the next PC: sequential, branch, register jump
//   or absolute jump. Also sequences boot, halt and trap, and counts retired
//   instructions.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC value loaded by reset
//   ROM_BYTES   256            instruction ROM size in bytes; targets beyond it trap
//   BOOT_CYCLES 1              cycles PC is held at RESET_PC after reset release (>=1)
// PORTS
//   CLK       in   1   clock, rising edge
//   RST       in   1   reset, asynchronous, active-low
//   PCWre     in   1   PC write enable; 0 = stall, hold PC
//   PCSrc     in   2   00 PC+4 | 01 branch | 10 register jump | 11 absolute jump
//   Imm       in   32  sign-extended branch offset, in words
//   RegAddr   in   32  register-jump target (byte address)
//   JumpAddr  in   26  absolute-jump word index
//   Halt      in   1   current instruction is halt
//   PC        out  32  current instruction address, to instruction ROM
//   PC4       out  32  PC+4, combinational (link value)
//   Running   out  1   1 only in RUN
//   Trap      out  1   1 only in TRAP
//   InstCount out  32  retired-instruction count
// BEHAVIOUR
//   Reset (RST=0, asynchronous, effective at any time including mid-operation):
//     PC=RESET_PC, InstCount=0, state=BOOT, Running=0, Trap=0.
//   Next-PC candidates, all arithmetic modulo 2^32:
//     PC4=PC+4; branch=PC4+(Imm<<2); reg=RegAddr; jump={PC4[31:28],JumpAddr,2'b00}.
//   Target is valid iff target[1:0]==0 and target <= ROM_BYTES-4, compared as an
//     unsigned 32-bit value. PC+4 is range-checked the same way.
//   States (2-bit encoded register):
//     BOOT   - PC held at RESET_PC for BOOT_CYCLES rising edges after reset
//              release, then RUN. Inputs ignored.
//     RUN    - PCWre=0: hold PC; InstCount unchanged.
//              PCWre=1 and Halt=1: go to HALTED; PC holds the halt address;
//                InstCount+1.
//              PCWre=1, Halt=0, target valid: PC<=target; InstCount+1.
//              PCWre=1, Halt=0, target invalid: go to TRAP; PC holds the
//                offending instruction address; InstCount unchanged.
//              Priority: Halt > validity check > update. PCSrc is ignored when
//                Halt=1.
//     HALTED - PC and InstCount frozen. Exit only by reset.
//     TRAP   - PC and InstCount frozen; Trap=1. Exit only by reset.
//   PC, Running, Trap and InstCount are registered; they change only on a CLK
//     edge or on reset assertion.
//   Latency: a selection made in cycle n appears on PC after the edge ending
//     cycle n, so the ROM sees the new address in cycle n+1.
//   InstCount wraps 32'hFFFF_FFFF -> 0 silently.
// TESTING
//   1 RST low then high, BOOT_CYCLES=1 -> PC=0 and Running=0 for 1 cycle, then
//     Running=1.
//   2 PCSrc=00 for 3 cycles -> PC 0,4,8,12; InstCount=3.
//   3 At PC=8, PCSrc=01, Imm=-2 -> PC=4. At PC=4, PCSrc=11, JumpAddr=0x10
//     -> PC=0x40.
//   4 PCSrc=10, RegAddr=0x102 (misaligned), then separately RegAddr=0x100
//     (out of range) -> Trap=1 in each case, PC unchanged, later inputs ignored.
//   5 PCWre=0 for 2 cycles -> PC and InstCount held. Halt=1 -> Running=0,
//     PC frozen, InstCount+1.
//   6 RST pulsed low mid-cycle while in RUN at PC=0x20 -> PC=0 immediately,
//     without waiting for a clock edge; InstCount=0; BOOT re-entered.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter feeding the instruction ROM: next-PC select, target range check, boot/halt/trap sequencing, retire count.
// New PC appears one edge after selection; PCWre=0 stalls (PC and count held); reset is asynchronous and immediate.
module pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ROM_BYTES   = 256,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Imm,
  input  logic [31:0] RegAddr,
  input  logic [25:0] JumpAddr,
  input  logic        Halt,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        Running,
  output logic        Trap,
  output logic [31:0] InstCount
);

  localparam int unsigned BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [31:0] PC_MAX    = 32'(ROM_BYTES - 4);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_TRAP   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   r_cnt;
  logic [31:0]   w_cnt_nxt;
  logic [BW-1:0] r_boot_cnt;
  logic [BW-1:0] w_boot_cnt_nxt;
  logic          r_running;
  logic          r_trap;

  logic [31:0]   w_pc4;
  logic [31:0]   w_branch;
  logic [31:0]   w_jump;
  logic [31:0]   w_target;
  logic          w_target_ok;

  assign w_pc4    = r_pc + 32'd4;
  assign w_branch = w_pc4 + (Imm << 2);
  assign w_jump   = {w_pc4[31:28], JumpAddr, 2'b00};

  always_comb begin
    w_target = w_pc4;
    case (PCSrc)
      2'b00:   w_target = w_pc4;
      2'b01:   w_target = w_branch;
      2'b10:   w_target = RegAddr;
      2'b11:   w_target = w_jump;
      default: w_target = w_pc4;
    endcase
  end

  // Unsigned compare: wrapped or huge targets fall outside the ROM and trap.
  assign w_target_ok = (w_target[1:0] == 2'b00) && (w_target <= PC_MAX);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_cnt_nxt      = r_cnt;
    w_boot_cnt_nxt = r_boot_cnt;
    case (r_state)
      S_BOOT: begin
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_nxt = S_RUN;
        end else begin
          w_boot_cnt_nxt = r_boot_cnt + BW'(1);
        end
      end
      S_RUN: begin
        if (PCWre) begin
          if (Halt) begin
            w_state_nxt = S_HALTED;
            w_cnt_nxt   = r_cnt + 32'd1;
          end else if (w_target_ok) begin
            w_pc_nxt  = w_target;
            w_cnt_nxt = r_cnt + 32'd1;
          end else begin
            w_state_nxt = S_TRAP;
          end
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      S_TRAP:   w_state_nxt = S_TRAP;
      default:  w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_cnt      <= 32'd0;
      r_boot_cnt <= '0;
      r_running  <= 1'b0;
      r_trap     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
      r_running  <= (w_state_nxt == S_RUN);
      r_trap     <= (w_state_nxt == S_TRAP);
    end
  end

  assign PC        = r_pc;
  assign PC4       = w_pc4;
  assign Running   = r_running;
  assign Trap      = r_trap;
  assign InstCount = r_cnt;

endmodule
